// File: rtl/iob_eth_echo_master_pkg.sv
// iob_eth_echo_master_pkg
//   Shared definitions for the iob_eth echo master: the iob_eth CPU-port
//   register map, buffer geometry, STATUS bit positions and the FSM state
//   encoding. No ports; imported by the bus sequencer, the top and the bench.
package iob_eth_echo_master_pkg;

  // Core geometry
  localparam int ETH_ADDR_W     = 13;  // register map + two 2 KiB buffer windows
  localparam int ETH_DATA_W     = 8;   // one buffer entry is one byte
  localparam int ETH_BUF_ADDR_W = 11;  // 2**11 = 2048 bytes per buffer

  // Register offsets on the iob_eth CPU port
  localparam int ETH_STATUS           = 0;
  localparam int ETH_CONTROL          = 1;
  localparam int ETH_TX_NBYTES        = 2;
  localparam int ETH_RX_NBYTES        = 3;
  localparam int ETH_SRC_MAC_ADDR_LO  = 4;
  localparam int ETH_SRC_MAC_ADDR_HI  = 5;
  localparam int ETH_DEST_MAC_ADDR_LO = 6;
  localparam int ETH_DEST_MAC_ADDR_HI = 7;
  localparam int ETH_TX_DATA          = 2048;  // TX buffer window base
  localparam int ETH_RX_DATA          = 4096;  // RX buffer window base

  // STATUS register bits
  localparam int ETH_STATUS_TX_READY_BIT = 0;
  localparam int ETH_STATUS_RX_READY_BIT = 1;

  // FSM states (4-bit). COPY is split into its read and write halves.
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_POLL_RX    = 4'd1,
    S_RD_NB      = 4'd2,
    S_RD_SRC_LO  = 4'd3,
    S_RD_SRC_HI  = 4'd4,
    S_WAIT_TX    = 4'd5,
    S_WR_DEST_LO = 4'd6,
    S_WR_DEST_HI = 4'd7,
    S_COPY_RD    = 4'd8,
    S_COPY_WR    = 4'd9,
    S_WR_NB      = 4'd10,
    S_SEND       = 4'd11,
    S_FLUSH      = 4'd12
  } echo_state_t;

  // A received length is usable when it is non-zero and fits the buffer.
  function automatic logic nb_is_valid(input logic [15:0] nb, input int buf_addr_w);
    return (nb != 16'd0) && (32'(nb) <= (32'd1 << buf_addr_w));
  endfunction

endpackage

// File: rtl/iob_eth_echo_master_bus_if.sv
// iob_eth_bus_if
//   Transaction sequencer for the iob_eth CPU port. The requester holds
//   req/rnw/a/d in registers for the whole transaction; this block maps them
//   onto sel/we/addr/wdata and reports completion.
//     read  : 2 cycles (A then B, same address); q is valid while done=1
//     write : 1 cycle; done=1 in that cycle
//   Handshake: a transaction is in flight while req=1; at the clock edge
//   where done=1 it is complete and the requester may present the next one
//   in the very next cycle (back-to-back, no idle gap). req must not change
//   while done=0.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     req, rnw, a, d      request: valid, read-not-write, address, write data
//     done, q             completion strobe, read data
//     sel, we, addr,
//     wdata, rdata        iob_eth CPU-port signals
module iob_eth_bus_if #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] a,
  input  logic [31:0]       d,
  output logic              done,
  output logic [31:0]       q,
  output logic              sel,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata
);

  // High during cycle B of a read.
  logic r_phase_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase_b <= 1'b0;
    end else begin
      r_phase_b <= req & rnw & ~r_phase_b;
    end
  end

  // The request fields are registers in the requester, so the bus is driven
  // straight from flops; only the write enable is qualified by req.
  assign sel   = req;
  assign we    = req & ~rnw;
  assign addr  = a;
  assign wdata = d;
  assign done  = req & (~rnw | r_phase_b);
  assign q     = rdata;

endmodule

// File: rtl/iob_eth_echo_master.sv
// iob_eth_echo_master
//   Autonomous bus initiator for the iob_eth CPU port: polls STATUS, reads a
//   received frame's length and source MAC, waits for the transmitter, sets
//   the destination MAC to that source, copies the RX buffer into the TX
//   buffer byte by byte, writes the length and triggers transmission.
//   Invalid lengths (0 or larger than the buffer) are flushed with one
//   dummy RX-data read and reported on drop.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     en             run the echo service (sampled in IDLE only)
//     sel, we, addr,
//     wdata, rdata   iob_eth CPU port (wdata -> data_in, rdata <- data_out)
//     busy           FSM is not in IDLE
//     frame_cnt      frames echoed, wraps at 16 bits
//     drop           one-cycle pulse per discarded frame
//     dbg_state      current FSM state
module iob_eth_echo_master
  import iob_eth_echo_master_pkg::*;
#(
  parameter int ADDR_W     = ETH_ADDR_W,
  parameter int DATA_W     = ETH_DATA_W,
  parameter int BUF_ADDR_W = ETH_BUF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              sel,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              drop,
  output logic [3:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] L_STATUS   = ADDR_W'(ETH_STATUS);
  localparam logic [ADDR_W-1:0] L_CONTROL  = ADDR_W'(ETH_CONTROL);
  localparam logic [ADDR_W-1:0] L_TX_NB    = ADDR_W'(ETH_TX_NBYTES);
  localparam logic [ADDR_W-1:0] L_RX_NB    = ADDR_W'(ETH_RX_NBYTES);
  localparam logic [ADDR_W-1:0] L_SRC_LO   = ADDR_W'(ETH_SRC_MAC_ADDR_LO);
  localparam logic [ADDR_W-1:0] L_SRC_HI   = ADDR_W'(ETH_SRC_MAC_ADDR_HI);
  localparam logic [ADDR_W-1:0] L_DEST_LO  = ADDR_W'(ETH_DEST_MAC_ADDR_LO);
  localparam logic [ADDR_W-1:0] L_DEST_HI  = ADDR_W'(ETH_DEST_MAC_ADDR_HI);
  localparam logic [ADDR_W-1:0] L_TX_DATA  = ADDR_W'(ETH_TX_DATA);
  localparam logic [ADDR_W-1:0] L_RX_DATA  = ADDR_W'(ETH_RX_DATA);

  echo_state_t           r_state;
  logic                  r_req;
  logic                  r_rnw;
  logic [ADDR_W-1:0]     r_a;
  logic [31:0]           r_d;
  logic [15:0]           r_nb;
  logic [47:0]           r_smac;
  logic [BUF_ADDR_W:0]   r_i;
  logic [15:0]           r_frame_cnt;
  logic                  r_drop;

  logic                  w_done;
  logic [31:0]           w_q;
  logic [BUF_ADDR_W:0]   w_i_nxt;
  logic [ADDR_W-1:0]     w_i_off;
  logic [ADDR_W-1:0]     w_i_nxt_off;
  logic                  w_copy_last;
  logic                  w_unused_q;

  iob_eth_bus_if #(.ADDR_W(ADDR_W)) u_bus_if (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (r_req),
    .rnw   (r_rnw),
    .a     (r_a),
    .d     (r_d),
    .done  (w_done),
    .q     (w_q),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Buffer offsets use only the low BUF_ADDR_W bits; the extra counter bit
  // exists so a full 2**BUF_ADDR_W-byte frame can reach i==nb.
  assign w_i_nxt     = r_i + 1'b1;
  assign w_i_off     = ADDR_W'(r_i[BUF_ADDR_W-1:0]);
  assign w_i_nxt_off = ADDR_W'(w_i_nxt[BUF_ADDR_W-1:0]);
  assign w_copy_last = (16'(w_i_nxt) == r_nb);

  // rdata[31:24] carries nothing this master consumes.
  assign w_unused_q  = &{1'b0, w_q[31:24]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_rnw       <= 1'b0;
      r_a         <= '0;
      r_d         <= '0;
      r_nb        <= '0;
      r_smac      <= '0;
      r_i         <= '0;
      r_frame_cnt <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state <= S_POLL_RX;
            r_req   <= 1'b1;
            r_rnw   <= 1'b1;
            r_a     <= L_STATUS;
          end
        end
        S_POLL_RX: begin
          if (w_done) begin
            if (w_q[ETH_STATUS_RX_READY_BIT]) begin
              r_state <= S_RD_NB;
              r_a     <= L_RX_NB;
            end else begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
              r_a     <= '0;
            end
          end
        end
        S_RD_NB: begin
          if (w_done) begin
            r_nb <= w_q[15:0];
            r_i  <= '0;
            if (nb_is_valid(w_q[15:0], BUF_ADDR_W)) begin
              r_state <= S_RD_SRC_LO;
              r_a     <= L_SRC_LO;
            end else begin
              r_state <= S_FLUSH;
              r_a     <= L_RX_DATA;
            end
          end
        end
        S_RD_SRC_LO: begin
          if (w_done) begin
            r_smac[23:0] <= w_q[23:0];
            r_state      <= S_RD_SRC_HI;
            r_a          <= L_SRC_HI;
          end
        end
        S_RD_SRC_HI: begin
          if (w_done) begin
            r_smac[47:24] <= w_q[23:0];
            r_state       <= S_WAIT_TX;
            r_a           <= L_STATUS;
          end
        end
        S_WAIT_TX: begin
          // While TX is busy the request stays up and STATUS is re-read.
          if (w_done && w_q[ETH_STATUS_TX_READY_BIT]) begin
            r_state <= S_WR_DEST_LO;
            r_rnw   <= 1'b0;
            r_a     <= L_DEST_LO;
            r_d     <= {8'h00, r_smac[23:0]};
          end
        end
        S_WR_DEST_LO: begin
          if (w_done) begin
            r_state <= S_WR_DEST_HI;
            r_a     <= L_DEST_HI;
            r_d     <= {8'h00, r_smac[47:24]};
          end
        end
        S_WR_DEST_HI: begin
          if (w_done) begin
            r_state <= S_COPY_RD;
            r_rnw   <= 1'b1;
            r_a     <= L_RX_DATA + w_i_off;
            r_d     <= '0;
          end
        end
        S_COPY_RD: begin
          if (w_done) begin
            r_state <= S_COPY_WR;
            r_rnw   <= 1'b0;
            r_a     <= L_TX_DATA + w_i_off;
            r_d     <= 32'(w_q[DATA_W-1:0]);
          end
        end
        S_COPY_WR: begin
          if (w_done) begin
            r_i <= w_i_nxt;
            if (w_copy_last) begin
              r_state <= S_WR_NB;
              r_a     <= L_TX_NB;
              r_d     <= {16'h0000, r_nb};
            end else begin
              r_state <= S_COPY_RD;
              r_rnw   <= 1'b1;
              r_a     <= L_RX_DATA + w_i_nxt_off;
              r_d     <= '0;
            end
          end
        end
        S_WR_NB: begin
          if (w_done) begin
            r_state <= S_SEND;
            r_a     <= L_CONTROL;
            r_d     <= 32'd1;
          end
        end
        S_SEND: begin
          if (w_done) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_a         <= '0;
            r_d         <= '0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        S_FLUSH: begin
          // The dummy read is what clears rx_ready inside the core.
          if (w_done) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_a     <= '0;
            r_drop  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_a     <= '0;
          r_d     <= '0;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign frame_cnt = r_frame_cnt;
  assign drop      = r_drop;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_iob_eth_echo_master.sv
// tb_iob_eth_echo_master
//   Bench for iob_eth_echo_master with a behavioural iob_eth CPU-port model
//   (registered read data, RX/TX buffers, rx_ready cleared by the first
//   RX-data read) and directed plus randomized frames.
module tb_iob_eth_echo_master;
  import iob_eth_echo_master_pkg::*;

  localparam int AW   = ETH_ADDR_W;
  localparam int BAW  = ETH_BUF_ADDR_W;
  localparam int NBUF = 2 ** BAW;

  // ---------------- clock / reset / DUT ----------------
  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            en    = 1'b0;
  logic            sel;
  logic            we;
  logic [AW-1:0]   addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata = '0;
  logic            busy;
  logic [15:0]     frame_cnt;
  logic            drop;
  logic [3:0]      dbg_state;

  always #5 clk = ~clk;

  iob_eth_echo_master #(
    .ADDR_W(AW), .DATA_W(ETH_DATA_W), .BUF_ADDR_W(BAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .sel(sel), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .frame_cnt(frame_cnt), .drop(drop), .dbg_state(dbg_state)
  );

  // ---------------- core model ----------------
  logic        tx_ready = 1'b1;
  int          posted   = 0;
  int          consumed = 0;
  logic [15:0] rx_nb    = '0;
  logic [47:0] rx_src   = '0;
  logic [7:0]  rx_buf [NBUF];
  logic        rx_rdy;
  int          gen      = 0;

  assign rx_rdy = (posted != consumed);

  function automatic logic [31:0] core_rd(input logic [AW-1:0] a);
    int ai;
    ai = int'(a);
    if (ai == ETH_STATUS)          return {30'h0, rx_rdy, tx_ready};
    if (ai == ETH_RX_NBYTES)       return {16'h0, rx_nb};
    if (ai == ETH_SRC_MAC_ADDR_LO) return {8'hA5, rx_src[23:0]};
    if (ai == ETH_SRC_MAC_ADDR_HI) return {8'h3C, rx_src[47:24]};
    if (ai >= ETH_RX_DATA && ai < ETH_RX_DATA + NBUF)
      return {24'hC3C3C3, rx_buf[ai - ETH_RX_DATA]};
    return 32'h0;
  endfunction

  // ---------------- bus monitor ----------------
  int          cyc = 0, wr_cnt = 0, ctrl_wr_cnt = 0, tx_wr_cnt = 0;
  int          status_rd = 0, rx0_rd = 0, drop_cnt = 0, proto_err = 0, bad_wr = 0;
  int          ctrl_cyc = 0, drop_cyc = 0, first_tx_cyc = 0, tx_max = 0, tx_min = 0;
  int          cur_gen = -1;
  logic [31:0] dest_lo = '0, dest_hi = '0, tx_nb_w = '0, ctrl_val = '0;
  logic [7:0]  tx_mem [NBUF];
  int          tx_gen [NBUF];
  logic        rd_ph = 1'b0;
  logic [AW-1:0] rd_a = '0;
  logic        in_tx, in_rx;
  logic [BAW-1:0] tx_idx;

  assign in_tx  = (int'(addr) >= ETH_TX_DATA) && (int'(addr) < ETH_TX_DATA + NBUF);
  assign in_rx  = (int'(addr) >= ETH_RX_DATA) && (int'(addr) < ETH_RX_DATA + NBUF);
  assign tx_idx = BAW'(int'(addr) - ETH_TX_DATA);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (drop) begin
      drop_cnt <= drop_cnt + 1;
      drop_cyc <= cyc;
    end
    if (sel && !we) begin
      rdata <= core_rd(addr);
      if (!rd_ph) begin
        rd_ph <= 1'b1;
        rd_a  <= addr;
        if (int'(addr) == ETH_STATUS)  status_rd <= status_rd + 1;
        if (int'(addr) == ETH_RX_DATA) rx0_rd <= rx0_rd + 1;
        if (in_rx && rx_rdy)           consumed <= consumed + 1;
      end else begin
        rd_ph <= 1'b0;
        if (addr != rd_a) proto_err <= proto_err + 1;
      end
    end else begin
      rd_ph <= 1'b0;
    end
    if (sel && we) begin
      wr_cnt <= wr_cnt + 1;
      if (in_tx) begin
        tx_wr_cnt      <= tx_wr_cnt + 1;
        tx_mem[tx_idx] <= wdata[7:0];
        tx_gen[tx_idx] <= gen;
        if (cur_gen != gen) begin
          cur_gen      <= gen;
          first_tx_cyc <= cyc;
          tx_max       <= int'(tx_idx);
          tx_min       <= int'(tx_idx);
        end else begin
          if (int'(tx_idx) > tx_max) tx_max <= int'(tx_idx);
          if (int'(tx_idx) < tx_min) tx_min <= int'(tx_idx);
        end
      end else begin
        case (int'(addr))
          ETH_DEST_MAC_ADDR_LO: dest_lo <= wdata;
          ETH_DEST_MAC_ADDR_HI: dest_hi <= wdata;
          ETH_TX_NBYTES:        tx_nb_w <= wdata;
          ETH_CONTROL: begin
            ctrl_wr_cnt <= ctrl_wr_cnt + 1;
            ctrl_val    <= wdata;
            ctrl_cyc    <= cyc;
          end
          default: bad_wr <= bad_wr + 1;
        endcase
      end
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("reach_idle", 32'(busy), 32'd0);
  endtask

  // Echo one frame; tx_busy_cyc > 0 holds tx_ready low that long after start.
  task automatic run_echo(input int nb, input logic [47:0] src, input bit pat,
                          input int tx_busy_cyc);
    int start, rise, c0, t0, n, bad;
    gen++;
    for (int k = 0; k < nb; k++)
      rx_buf[k] = pat ? (8'(k) ^ 8'h5A) : 8'($urandom_range(0, 255));
    rx_nb    = 16'(nb);
    rx_src   = src;
    tx_ready = (tx_busy_cyc == 0);
    c0 = ctrl_wr_cnt;
    t0 = tx_wr_cnt;
    posted++;
    en    = 1'b1;
    start = cyc;
    rise  = start;
    if (tx_busy_cyc > 0) begin
      repeat (tx_busy_cyc) @(negedge clk);
      check("txbusy_no_tx_wr", 32'(tx_wr_cnt - t0), 32'd0);
      tx_ready = 1'b1;
      rise = cyc;
    end
    n = 0;
    while (ctrl_wr_cnt == c0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("echo_ctrl_wr", 32'(ctrl_wr_cnt - c0), 32'd1);
    exp_frames = (exp_frames + 1) & 16'hFFFF;
    check("dest_lo", dest_lo, {8'h00, src[23:0]});
    check("dest_hi", dest_hi, {8'h00, src[47:24]});
    check("tx_nbytes", tx_nb_w, 32'(nb));
    check("control", ctrl_val, 32'd1);
    check("tx_wr_count", 32'(tx_wr_cnt - t0), 32'(nb));
    bad = 0;
    for (int k = 0; k < nb; k++)
      if (tx_gen[k] != gen || tx_mem[k] !== rx_buf[k]) bad++;
    check("tx_bytes", 32'(bad), 32'd0);
    check("tx_max_idx", 32'(tx_max), 32'(nb - 1));
    check("tx_min_idx", 32'(tx_min), 32'd0);
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    if (tx_busy_cyc == 0)
      check("ctrl_cycle", 32'(ctrl_cyc - start), 32'(15 + 3 * nb - 1));
    else
      check("tx_after_ready", 32'(first_tx_cyc >= rise), 32'd1);
    en = 1'b0;
    wait_idle();
  endtask

  task automatic run_drop(input int nb);
    int start, r0, d0, w0, n;
    gen++;
    rx_nb = 16'(nb);
    r0 = rx0_rd;
    d0 = drop_cnt;
    w0 = wr_cnt;
    posted++;
    en    = 1'b1;
    start = cyc;
    n = 0;
    while (drop_cnt == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    en = 1'b0;
    wait_idle();
    check("drop_pulses", 32'(drop_cnt - d0), 32'd1);
    check("drop_cycle", 32'(drop_cyc - start), 32'd7);
    check("drop_rx0_reads", 32'(rx0_rd - r0), 32'd1);
    check("drop_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("drop_rx_cleared", 32'(rx_rdy), 32'd0);
    check("drop_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0, w0, sel_n, bad_a, bsy_mis, t0, n;
    logic [63:0] r64;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // Idle poll: nothing received
    rst_n = 1'b1;
    en    = 1'b1;
    s0 = status_rd;
    w0 = wr_cnt;
    sel_n = 0; bad_a = 0; bsy_mis = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sel) sel_n++;
      if (sel && int'(addr) != ETH_STATUS) bad_a++;
      if (sel != busy) bsy_mis++;
    end
    check("poll_sel_cycles", 32'(sel_n), 32'd20);
    check("poll_status_reads", 32'(status_rd - s0), 32'd10);
    check("poll_addr", 32'(bad_a), 32'd0);
    check("poll_busy_eq_sel", 32'(bsy_mis), 32'd0);
    check("poll_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("poll_frame_cnt", 32'(frame_cnt), 32'd0);
    en = 1'b0;
    wait_idle();

    // 64-byte echo with the i^0x5A pattern
    run_echo(64, 48'h0123_4567_89AB, 1'b1, 0);

    // TX busy for 40 cycles
    r64 = {$urandom, $urandom};
    run_echo(24, r64[47:0], 1'b0, 40);

    // Invalid lengths
    run_drop(0);
    run_drop(2049);

    // Full buffer
    r64 = {$urandom, $urandom};
    run_echo(NBUF, r64[47:0], 1'b0, 0);

    // Randomized frames and the single-byte edge
    for (int r = 0; r < 3; r++) begin
      r64 = {$urandom, $urandom};
      run_echo($urandom_range(1, 150), r64[47:0], 1'b0, 0);
    end
    r64 = {$urandom, $urandom};
    run_echo(1, r64[47:0], 1'b0, 0);

    // Reset in the middle of COPY
    gen++;
    for (int k = 0; k < 64; k++) rx_buf[k] = 8'($urandom_range(0, 255));
    rx_nb    = 16'd64;
    tx_ready = 1'b1;
    t0 = tx_wr_cnt;
    posted++;
    en = 1'b1;
    n = 0;
    while ((tx_wr_cnt - t0) < 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("mid_copy_bytes", 32'(tx_wr_cnt - t0), 32'd10);
    rst_n = 1'b0;
    @(negedge clk);
    exp_frames = 0;
    check("mrst_sel", 32'(sel), 32'd0);
    check("mrst_we", 32'(we), 32'd0);
    check("mrst_addr", 32'(addr), 32'd0);
    check("mrst_wdata", wdata, 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_drop", 32'(drop), 32'd0);
    check("mrst_frame_cnt", 32'(frame_cnt), 32'd0);
    w0 = wr_cnt;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_restart_state", 32'(dbg_state), 32'(S_POLL_RX));
    check("mrst_restart_addr", 32'(addr), 32'(ETH_STATUS));
    check("mrst_restart_sel", 32'(sel), 32'd1);
    repeat (12) @(negedge clk);
    check("mrst_no_writes", 32'(wr_cnt - w0), 32'd0);
    en = 1'b0;
    wait_idle();

    check("read_protocol", 32'(proto_err), 32'd0);
    check("stray_writes", 32'(bad_wr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
